// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: first-word-fall-through valid/ready buffer with occupancy and transfer counter
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data is the head word
//   count, full, empty    occupancy 0..DEPTH and its derived flags
//   xfer_count            completed output transfers, wraps modulo 2^CNT_W
module leaf_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         xfer_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic              push, pop;

    assign full      = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    // rst gating keeps upstream from handing over a word that the reset edge would discard
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // storage is never cleared; push is already blocked while rst is high
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            xfer_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                xfer_count <= xfer_count + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_leaf_stream_fifo.sv
// tb_leaf_stream_fifo: scoreboard bench comparing the buffer against a queue-based reference
module tb_leaf_stream_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic              clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, out_valid, full, empty;
    logic [DATA_W-1:0] out_data;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]  xfer_count;

    leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [DATA_W-1:0] sb [$];
    int mcnt = 0;
    logic [CNT_W-1:0] mx = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference: a word is accepted when the buffer has room and reset is low; it leaves when
    // the consumer is ready and something is held; reset empties everything and zeroes the tally
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            mcnt <= 0;
            mx   <= '0;
        end else begin
            if (in_valid && mcnt < DEPTH) sb.push_back(in_data);
            mcnt <= mcnt + int'(in_valid && mcnt < DEPTH) - int'(out_ready && mcnt > 0);
            if (out_ready && mcnt > 0) mx <= mx + 1'b1;
        end
    end

    // monitor: status against the reference, head word against the scoreboard
    always @(negedge clk) begin
        chk("count", 32'(count), 32'(mcnt));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("full", 32'(full), 32'(mcnt == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mcnt > 0));
        chk("in_ready", 32'(in_ready), 32'(!rst && mcnt < DEPTH));
        chk("xfer_count", 32'(xfer_count), 32'(mx));
        if (out_valid) begin
            if (sb.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            else begin
                chk("out_data", 32'(out_data), 32'(sb[0]));
                if (out_ready && !rst) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic r);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
    endtask

    initial begin
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // fill, then an ignored fifth word, then drain
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0);
        drive(1, 8'h44, 0, 0);
        drive(1, 8'h55, 0, 0);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        // stream through
        for (int i = 0; i < 10; i++) drive(1, 8'(i), 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        // full with simultaneous pop
        for (int i = 0; i < 4; i++) drive(1, 8'hC0 + 8'(i), 0, 0);
        drive(1, 8'hD0, 1, 0);
        drive(1, 8'hD1, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0);
        // backpressure hold
        drive(1, 8'h77, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 8'h80 + 8'(i), 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
        // reset mid-stream
        for (int i = 0; i < 3; i++) drive(1, 8'h30 + 8'(i), 0, 0);
        drive(0, 0, 1, 1);
        drive(1, 8'hA5, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        // randomized traffic with occasional reset; counter wraps several times
        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 199) == 0));
        drive(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("final_drain", 32'(sb.size()), 32'(mcnt));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
